// File: rtl/console_io_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : console_io_pkg
// Brief    : GPIO bit positions, drop-counter width and shared helpers for the
//            console bridge between the AXI GPIO pair and the CPU console.
// Revision : 1.0 - initial release
// ============================================================================
package console_io_pkg;

   // Host-to-bridge control strobes on AXI_GPIO_input
   localparam int WR_STB    = 16;
   localparam int RD_STB    = 17;
   localparam int CLR_STB   = 18;
   localparam int FLUSH_STB = 19;

   // Status bits on AXI_GPIO_output
   localparam int ST_OUT_EMPTY = 16;
   localparam int ST_OUT_FULL  = 17;
   localparam int ST_IN_EMPTY  = 18;
   localparam int ST_IN_FULL   = 19;
   localparam int ST_OVF       = 20;
   localparam int ST_UDF       = 21;
   localparam int DROP_LSB     = 24;
   localparam int DROP_W       = 8;

   // Strobe group in GPIO bit order, flush in the MSB
   typedef struct packed {
      logic flush;
      logic clr;
      logic rd;
      logic wr;
   } strobe_t;

   // Increment that sticks at all-ones
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
   endfunction

endpackage
`default_nettype wire

// File: rtl/console_io_fifo_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Brief    : Single-clock first-word-fall-through FIFO with flush. Head is read
//            straight from storage and forced to zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable
   assign count = wr_ptr - rd_ptr;
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // Pop only real data; a pop on full frees the slot for a same-cycle push
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; flush discards all contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/console_io_fifo.sv
`default_nettype none
// ============================================================================
// Module   : console_io_fifo
// Brief    : Console bridge between the AXI GPIO pair and the CPU console
//            put/get methods: edge-detected host strobes, input and output
//            FWFT FIFOs, sticky overflow/underflow flags and a drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module console_io_fifo
   import console_io_pkg::*;
#(
   parameter  int DATA_W    = 8,
   parameter  int IN_DEPTH  = 16,
   parameter  int OUT_DEPTH = 16,
   localparam int ICW       = $clog2(IN_DEPTH) + 1,
   localparam int OCW       = $clog2(OUT_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       AXI_GPIO_input,
   output logic [31:0]       AXI_GPIO_output,
   input  logic              cpu_reset_completed,
   input  logic              RDY_put_from_console_put,
   output logic [DATA_W-1:0] put_from_console_put,
   output logic              EN_put_from_console_put,
   input  logic [DATA_W-1:0] get_to_console_get,
   input  logic              RDY_get_to_console_get,
   output logic              EN_get_to_console_get,
   output logic [ICW-1:0]    input_fifo_counter,
   output logic [OCW-1:0]    output_fifo_counter
);

   strobe_t             strb_now;
   strobe_t             strb_prev;
   strobe_t             rise;
   logic                in_empty, in_full, out_empty, out_full;
   logic [DATA_W-1:0]   out_head;
   logic                ovf_evt, udf_evt;
   logic                ovf_flag, udf_flag;
   logic [DROP_W-1:0]   drop_cnt;
   logic [31:0]         gpio;
   logic                unused_bits;

   assign strb_now = strobe_t'(AXI_GPIO_input[FLUSH_STB:WR_STB]);
   assign rise     = strobe_t'(strb_now & ~strb_prev);

   // Only the char field and the four strobes are decoded
   assign unused_bits = ^AXI_GPIO_input;

   // Previous-cycle strobe levels for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) strb_prev <= '0;
      else     strb_prev <= strb_now;
   end

   // CPU-side handshakes; full is judged before any same-cycle host pop
   assign EN_put_from_console_put = cpu_reset_completed & RDY_put_from_console_put
                                    & ~in_empty & ~rise.flush;
   assign EN_get_to_console_get   = cpu_reset_completed & RDY_get_to_console_get
                                    & ~out_full & ~rise.flush;

   sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rise.wr),
      .pop   (EN_put_from_console_put),
      .flush (rise.flush),
      .din   (AXI_GPIO_input[DATA_W-1:0]),
      .head  (put_from_console_put),
      .count (input_fifo_counter),
      .empty (in_empty),
      .full  (in_full)
   );

   sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (EN_get_to_console_get),
      .pop   (rise.rd),
      .flush (rise.flush),
      .din   (get_to_console_get),
      .head  (out_head),
      .count (output_fifo_counter),
      .empty (out_empty),
      .full  (out_full)
   );

   // A write is lost only when full and the CPU is not freeing a slot
   assign ovf_evt = rise.wr & in_full & ~EN_put_from_console_put;
   assign udf_evt = rise.rd & out_empty;

   // Sticky flags and drop counter; a same-cycle event beats a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_flag <= 1'b0;
         udf_flag <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (ovf_evt)       ovf_flag <= 1'b1;
         else if (rise.clr) ovf_flag <= 1'b0;

         if (udf_evt)       udf_flag <= 1'b1;
         else if (rise.clr) udf_flag <= 1'b0;

         if (ovf_evt)       drop_cnt <= rise.clr ? {{(DROP_W-1){1'b0}}, 1'b1} : sat_inc(drop_cnt);
         else if (rise.clr) drop_cnt <= '0;
      end
   end

   // Status word assembly; every status source is a register or pointer-derived
   always_comb begin
      gpio                      = '0;
      gpio[DATA_W-1:0]          = out_head;
      gpio[ST_OUT_EMPTY]        = out_empty;
      gpio[ST_OUT_FULL]         = out_full;
      gpio[ST_IN_EMPTY]         = in_empty;
      gpio[ST_IN_FULL]          = in_full;
      gpio[ST_OVF]              = ovf_flag;
      gpio[ST_UDF]              = udf_flag;
      gpio[DROP_LSB +: DROP_W]  = drop_cnt;
   end

   assign AXI_GPIO_output = gpio;

endmodule
`default_nettype wire

// File: tb/tb_console_io_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_console_io_fifo
// Brief    : Self-checking bench for console_io_fifo with 4-deep FIFOs and a
//            queue scoreboard for chars flowing in each direction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_console_io_fifo;

   localparam int DW  = 8;
   localparam int ID  = 4;
   localparam int OD  = 4;
   localparam int ICW = 3;
   localparam int OCW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    gin;
   logic [31:0]    gout;
   logic           crc, rdy_put, rdy_get, en_put, en_get;
   logic [DW-1:0]  put_data, get_data;
   logic [ICW-1:0] icnt;
   logic [OCW-1:0] ocnt;

   int checks    = 0;
   int errors    = 0;
   int put_fires = 0;
   int get_fires = 0;
   int pf, gf;

   logic [7:0] exp_put [$];
   logic [7:0] exp_out [$];

   console_io_fifo #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .AXI_GPIO_input           (gin),
      .AXI_GPIO_output          (gout),
      .cpu_reset_completed      (crc),
      .RDY_put_from_console_put (rdy_put),
      .put_from_console_put     (put_data),
      .EN_put_from_console_put  (en_put),
      .get_to_console_get       (get_data),
      .RDY_get_to_console_get   (rdy_get),
      .EN_get_to_console_get    (en_get),
      .input_fifo_counter       (icnt),
      .output_fifo_counter      (ocnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int b, input logic [7:0] d);
      gin = {24'd0, d} | (32'd1 << b);
      step(1);
      gin = '0;
      step(1);
   endtask

   task automatic offer_get(input logic [7:0] c);
      get_data = c;
      rdy_get  = 1'b1;
      step(1);
      rdy_get  = 1'b0;
      step(1);
   endtask

   // Mid-cycle sampling of the CPU handshakes; put data checked against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (en_put) begin
            put_fires++;
            if (exp_put.size() == 0) check("put_unexpected", 32'd1, 32'd0);
            else                     check("put_data", {24'd0, put_data}, {24'd0, exp_put.pop_front()});
         end
         if (en_get) get_fires++;
      end
   end

   initial begin
      rst = 1'b1; gin = '0; crc = 1'b1; rdy_put = 1'b0; rdy_get = 1'b0; get_data = '0;
      step(3);
      rst = 1'b0;
      step(1);

      // Reset state
      check("rst_gpio",   gout, 32'h0005_0000);
      check("rst_en_put", {31'd0, en_put}, 32'd0);
      check("rst_en_get", {31'd0, en_get}, 32'd0);
      check("rst_icnt",   {29'd0, icnt}, 32'd0);
      check("rst_ocnt",   {29'd0, ocnt}, 32'd0);

      // Held strobe pushes exactly once
      gin = 32'h0001_00FF;
      step(3);
      gin = '0;
      step(1);
      exp_put.push_back(8'hFF);
      check("t2_icnt_held", {29'd0, icnt}, 32'd1);
      pf = put_fires;
      rdy_put = 1'b1;
      step(3);
      rdy_put = 1'b0;
      check("t2_put_count", put_fires - pf, 32'd1);
      check("t2_icnt_zero", {29'd0, icnt}, 32'd0);
      check("t2_in_empty",  {31'd0, gout[18]}, 32'd1);

      // Overflow on the fifth write into a 4-deep FIFO
      for (int i = 0; i < 5; i++) begin
         pulse(16, 8'hF0 + 8'(i));
         if (i < 4) exp_put.push_back(8'hF0 + 8'(i));
      end
      check("t3_icnt_full", {29'd0, icnt}, 32'd4);
      check("t3_in_full",   {31'd0, gout[19]}, 32'd1);
      check("t3_ovf",       {31'd0, gout[20]}, 32'd1);
      check("t3_drop",      {24'd0, gout[31:24]}, 32'd1);
      pf = put_fires;
      rdy_put = 1'b1;
      step(5);
      rdy_put = 1'b0;
      check("t3_put_count", put_fires - pf, 32'd4);
      check("t3_icnt_zero", {29'd0, icnt}, 32'd0);

      // CPU to host path and underflow
      gf = get_fires;
      offer_get(8'hAA); exp_out.push_back(8'hAA);
      offer_get(8'hAB); exp_out.push_back(8'hAB);
      offer_get(8'hAC); exp_out.push_back(8'hAC);
      check("t4_get_count", get_fires - gf, 32'd3);
      check("t4_ocnt",      {29'd0, ocnt}, 32'd3);
      check("t4_head",      {24'd0, gout[7:0]}, {24'd0, exp_out[0]});
      check("t4_udf_clear", {31'd0, gout[21]}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         pulse(17, 8'h00);
         void'(exp_out.pop_front());
         if (exp_out.size() > 0) check("t4_head_next", {24'd0, gout[7:0]}, {24'd0, exp_out[0]});
         else                    check("t4_out_empty", {31'd0, gout[16]}, 32'd1);
      end
      pulse(17, 8'h00);
      check("t4_udf",       {31'd0, gout[21]}, 32'd1);
      check("t4_ocnt_zero", {29'd0, ocnt}, 32'd0);

      // CPU not out of reset: host writes still land, no CPU transfers
      crc = 1'b0; rdy_put = 1'b1; rdy_get = 1'b1; get_data = 8'h55;
      pf = put_fires; gf = get_fires;
      pulse(16, 8'h31); exp_put.push_back(8'h31);
      pulse(16, 8'h32); exp_put.push_back(8'h32);
      check("t5_no_put",  put_fires - pf, 32'd0);
      check("t5_no_get",  get_fires - gf, 32'd0);
      check("t5_icnt",    {29'd0, icnt}, 32'd2);
      check("t5_ocnt",    {29'd0, ocnt}, 32'd0);
      rdy_get = 1'b0;
      crc = 1'b1;
      step(4);
      rdy_put = 1'b0;
      check("t5_drain",      put_fires - pf, 32'd2);
      check("t5_icnt_zero",  {29'd0, icnt}, 32'd0);

      // Fill output FIFO, refuse a get when full, then flush and clear
      for (int i = 0; i < 4; i++) begin
         offer_get(8'h10 + 8'(i));
         exp_out.push_back(8'h10 + 8'(i));
      end
      check("t6_ocnt_full", {29'd0, ocnt}, 32'd4);
      check("t6_out_full",  {31'd0, gout[17]}, 32'd1);
      check("t6_head",      {24'd0, gout[7:0]}, {24'd0, exp_out[0]});
      gf = get_fires;
      offer_get(8'h99);
      check("t6_no_get_full", get_fires - gf, 32'd0);
      pulse(16, 8'h41);
      pulse(16, 8'h42);
      check("t6_icnt", {29'd0, icnt}, 32'd2);
      gin = (32'd1 << 19) | (32'd1 << 16) | 32'h77;
      step(1);
      gin = '0;
      step(1);
      exp_out.delete();
      check("t6_flush_icnt", {29'd0, icnt}, 32'd0);
      check("t6_flush_ocnt", {29'd0, ocnt}, 32'd0);
      check("t6_out_empty",  {31'd0, gout[16]}, 32'd1);
      check("t6_in_empty",   {31'd0, gout[18]}, 32'd1);
      check("t6_ovf_kept",   {31'd0, gout[20]}, 32'd1);
      pulse(18, 8'h00);
      check("t6_clr_ovf",  {31'd0, gout[20]}, 32'd0);
      check("t6_clr_udf",  {31'd0, gout[21]}, 32'd0);
      check("t6_clr_drop", {24'd0, gout[31:24]}, 32'd0);
      check("t6_gpio",     gout, 32'h0005_0000);

      check("sb_put_drained", exp_put.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/console_io_fifo.md
Name: console_io_fifo

Overview:
Parametrised successor to the console bridge between the PS-side AXI GPIO pair and the CPU console put/get methods. It has an input FIFO (host to CPU) and an output FIFO (CPU to host), each with configurable width and depth. New over the previous generation: edge-detected GPIO strobes, so one push or pop happens per strobe pulse; sticky overflow/underflow flags; a saturating drop counter; flush and clear controls; and a status word on the GPIO output. Sits between the AXI GPIO IP and the Bluespec core's console interface.

Parameters:
DATA_W, 8, character width; legal range 1..16.
IN_DEPTH, 16, input FIFO depth; power of two, at least 2.
OUT_DEPTH, 16, output FIFO depth; power of two, at least 2.
ICW/OCW, derived, $clog2(IN_DEPTH)+1 and $clog2(OUT_DEPTH)+1 (localparams).

Ports:
clk  in  1  single clock, also the GPIO clock domain (no resynchronisation).
rst  in  1  asynchronous, active-high reset.
AXI_GPIO_input  in  32  [DATA_W-1:0] tx char; [16] write strobe; [17] read strobe; [18] clear sticky; [19] flush.
AXI_GPIO_output  out  32  [DATA_W-1:0] output FIFO head; [16] out empty; [17] out full; [18] in empty; [19] in full; [20] overflow sticky; [21] underflow sticky; [31:24] drop count; all other bits 0.
cpu_reset_completed  in  1  gates all CPU-side transfers.
RDY_put_from_console_put  in  1  CPU can accept a char.
put_from_console_put  out  DATA_W  input FIFO head.
EN_put_from_console_put  out  1  put fires this cycle.
get_to_console_get  in  DATA_W  char from the CPU.
RDY_get_to_console_get  in  1  CPU has a char.
EN_get_to_console_get  out  1  get fires this cycle (char captured).
input_fifo_counter  out  ICW  input FIFO occupancy.
output_fifo_counter  out  OCW  output FIFO occupancy.

Behaviour:
- Reset (async, active-high): FIFOs empty, edge registers 0, sticky flags 0, drop count 0. AXI_GPIO_output = 0x0005_0000 (bits 16 and 18 set). EN_* = 0. Counters = 0.
- Edge detection: register bits 16, 17, 18 and 19 of the previous cycle. rise_x = in[x] & ~prev[x]. Any action fires once per rising edge, at the clock edge where the rise is first seen. A strobe held high for N cycles causes exactly one action.
- Write (rise 16):
  - Not full: push in[DATA_W-1:0].
  - Full and no pop this cycle: char dropped, overflow sets, drop count +1 saturating at 255.
  - Full with a pop in the same cycle: push accepted, count unchanged.
- Put:
  - EN_put = cpu_reset_completed & RDY_put & ~in_empty, combinational.
  - put_from_console_put = input FIFO head (FWFT); it equals 0 when empty.
  - The pop occurs at the clock edge where EN_put = 1.
- Get:
  - EN_get = cpu_reset_completed & RDY_get & ~out_full, combinational.
  - The char is pushed at that edge.
  - Full with a host pop in the same cycle: EN_get still 0. Full is evaluated before the pop.
- Read (rise 17):
  - Not empty: pop; the GPIO head updates the next cycle.
  - Empty: underflow sets, no state change.
- GPIO head [DATA_W-1:0] shows the output FIFO head combinationally from FIFO storage, and is 0 when empty.
- Clear (rise 18): clears overflow, underflow and drop count. If a new overflow or underflow event occurs in the same cycle, the event wins: the flag is set and the count is 1.
- Flush (rise 19):
  - Empties both FIFOs and overrides any push/pop in the same cycle; EN_put and EN_get are forced to 0 that cycle.
  - Sticky flags are not affected.
- Simultaneous push and pop on an empty FIFO: the push is stored, the pop is suppressed (nothing to pop), and count becomes 1.
- Pointers wrap modulo depth. Occupancy derives from pointers with one extra bit. Full means count == DEPTH.
- Status bits [16:21] are registered: they reflect state after the last edge, with no combinational path from the inputs.
- cpu_reset_completed = 0: host-side writes and reads still operate; CPU-side transfers stall.
- Reset asserted mid-transfer: state is lost immediately and no EN_* pulse completes.

Decomposition:
- console_io_pkg: GPIO bit-position constants (WR_STB=16, RD_STB=17, CLR=18, FLUSH=19, ST_* status bits, DROP_LSB=24) and the drop-count width.
- One sub-module: sync_fifo_fwft #(WIDTH, DEPTH), with push/pop/flush, head, count, empty and full. It is instantiated twice.

Test Plan:
Defaults overridden to DATA_W=8, IN_DEPTH=4, OUT_DEPTH=4.
1. Assert and release rst -> AXI_GPIO_output=0x00050000, EN_put=0, EN_get=0, both counters 0.
2. RDY_put=0, data 0xFF, strobe held high 3 cycles -> input_fifo_counter=1. Then RDY_put=1 -> a single EN_put cycle with put=0xFF; counter returns to 0 and bit18=1.
3. RDY_put=0, 5 strobe pulses 0xF0..0xF4 -> counter=4, bit19=1, bit20=1, [31:24]=1. Then RDY_put=1 -> EN_put for 4 consecutive cycles with F0, F1, F2, F3.
4. CPU offers 0xAA, 0xAB, 0xAC via 1-cycle RDY_get pulses -> 3 EN_get pulses, output counter=3, GPIO[7:0]=0xAA. Three read-strobe pulses -> 0xAB, 0xAC, then bit16=1. A 4th pulse -> bit21=1 and counter stays 0.
5. cpu_reset_completed=0 with RDY_put=1, RDY_get=1 and 2 write strobes -> no EN pulses and input counter=2. Raise cpu_reset_completed -> both chars drain in order.
6. Output FIFO filled to 4, input FIFO at 2. Flush rise in the same cycle as a write strobe -> both counters 0, bits 16 and 18 set, bit20 unchanged. Clear rise -> bits 20 and 21 = 0 and [31:24]=0.
